// File: rtl/n_acc_pkg.sv
// Shared constants and types for the accumulator drain stage.
// The last column holds the checksum of the data columns.
package n_acc_pkg;

    localparam int ARRAY_SIZE = 4;
    localparam int ADDR_W     = 2;
    localparam int Z_BITS     = 12;
    localparam int LEN_BITS   = 8;
    localparam int CNT_W      = LEN_BITS + ADDR_W + 1;
    localparam int CHK_COL    = ARRAY_SIZE - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef logic [ARRAY_SIZE-1:0][Z_BITS-1:0] cap_vec_t;

    // A zero-length window still covers one beat.
    function automatic logic [LEN_BITS-1:0] eff_len(input logic [LEN_BITS-1:0] len);
        return (len == '0) ? LEN_BITS'(1) : len;
    endfunction

endpackage

// File: rtl/acc_chk_sum.sv
// Sums the captured data columns and compares them with the checksum column.
// The result is held in a register loaded once per window.
module acc_chk_sum
    import n_acc_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  cap_vec_t cap,
    output logic     err
);

    logic [Z_BITS-1:0] sum;
    logic              err_q;
    logic              err_d;

    // The sum wraps at Z_BITS, matching the accumulators' own width.
    always_comb begin
        sum = '0;
        for (int k = 0; k < CHK_COL; k++) begin
            sum = sum + cap[k];
        end
    end

    always_comb begin
        err_d = err_q;
        if (load) begin
            err_d = (sum != cap[CHK_COL]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/n_acc_drain.sv
// Issues skewed column clears, captures each column at window close, checks the
// checksum column and drains the four results over a valid/ready stream.
module n_acc_drain
    import n_acc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_BITS-1:0] len,
    output logic                busy,
    output logic                clear_0,
    output logic                clear_1,
    output logic                clear_2,
    output logic                clear_3,
    input  logic [Z_BITS-1:0]   z_0,
    input  logic [Z_BITS-1:0]   z_1,
    input  logic [Z_BITS-1:0]   z_2,
    input  logic [Z_BITS-1:0]   z_3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [Z_BITS-1:0]   out_data,
    output logic [ADDR_W-1:0]   out_col,
    output logic                out_last,
    output logic                chk_err,
    output logic                done
);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [LEN_BITS-1:0]     len_q, len_d;
    cap_vec_t                cap_q, cap_d;
    cap_vec_t                z_vec;
    logic [ARRAY_SIZE-1:0]   clear_q, clear_d;
    logic [ARRAY_SIZE-1:0]   clr_hit;
    logic [ARRAY_SIZE-1:0]   cap_hit;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic [ADDR_W-1:0]       idx_inc;
    logic                    busy_q, busy_d;
    logic                    out_valid_q, out_valid_d;
    logic [Z_BITS-1:0]       out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic                    chk_err_q, chk_err_d;
    logic                    done_q, done_d;
    logic                    err_load;
    logic                    err;

    assign z_vec   = {z_3, z_2, z_1, z_0};
    assign cnt_nxt = cnt_q + CNT_W'(1);
    assign idx_inc = idx_q + ADDR_W'(1);

    // Column k is cleared at c == k and captured at c == k + L.
    // Clears are registered, so they are decoded from the next counter value.
    generate
        for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_col
            assign clr_hit[gi] = (cnt_nxt == CNT_W'(gi));
            assign cap_hit[gi] = (cnt_q == CNT_W'(gi) + CNT_W'(len_q));
            assign cap_d[gi]   = (state_q == S_ACC && cap_hit[gi]) ? z_vec[gi] : cap_q[gi];
        end
    endgenerate

    acc_chk_sum u_chk (
        .clk  (clk),
        .rst  (rst),
        .load (err_load),
        .cap  (cap_d),
        .err  (err)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        clear_d     = '0;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        chk_err_d   = chk_err_q;
        done_d      = 1'b0;
        err_load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACC;
                    cnt_d   = '0;
                    len_d   = eff_len(len);
                    clear_d = ARRAY_SIZE'(1);
                end
            end
            S_ACC: begin
                cnt_d   = cnt_nxt;
                clear_d = clr_hit;
                if (cap_hit[CHK_COL]) begin
                    state_d     = S_DRAIN;
                    clear_d     = '0;
                    err_load    = 1'b1;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = cap_d[0];
                    out_last_d  = 1'b0;
                    chk_err_d   = 1'b0;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (idx_q == ADDR_W'(CHK_COL)) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        chk_err_d   = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        idx_d      = idx_inc;
                        out_data_d = cap_q[idx_inc];
                        out_last_d = (idx_inc == ADDR_W'(CHK_COL));
                        chk_err_d  = err & (idx_inc == ADDR_W'(CHK_COL));
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            cap_q       <= '0;
            clear_q     <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            chk_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            cap_q       <= cap_d;
            clear_q     <= clear_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            chk_err_q   <= chk_err_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign clear_0   = clear_q[0];
    assign clear_1   = clear_q[1];
    assign clear_2   = clear_q[2];
    assign clear_3   = clear_q[3];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_col   = idx_q;
    assign out_last  = out_last_q;
    assign chk_err   = chk_err_q;
    assign done      = done_q;

endmodule
